mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arb_pkg.sv | 34 +++
 rtl/rr_arbiter.sv | 33 +++
 rtl/mem_arbiter.sv | 193 +++++++++++++++++++
 tb/tb_mem_arbiter.sv | 296 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// Shared encodings and default widths for the memory arbiter slice.
package mem_arb_pkg;

    localparam int DEF_NUM_PORTS = 2;
    localparam int DEF_ADDR_W    = 64;
    localparam int DEF_DATA_W    = 64;
    localparam int DEF_RAM_LAT   = 1;

    typedef enum logic [1:0] {
        OP_RSVD0 = 2'b00,
        OP_LOAD  = 2'b01,
        OP_STORE = 2'b10,
        OP_RSVD3 = 2'b11
    } mem_op_e;

    typedef enum logic [1:0] {
        FAULT_NONE     = 2'b00,
        FAULT_ACCESS   = 2'b01,
        FAULT_MISALIGN = 2'b10,
        FAULT_ILLEGAL  = 2'b11
    } fault_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_ISSUE = 2'b01,
        ST_WAIT  = 2'b10,
        ST_RESP  = 2'b11
    } arb_state_e;

    function automatic logic op_is_legal(input logic [1:0] op);
        return (op == OP_LOAD) || (op == OP_STORE);
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin grant: first requester after last_grant_i, wrapping, one-hot out.
module rr_arbiter
#(
    parameter int  NUM_PORTS = 2,
    localparam int PORT_W    = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1
) (
    input  logic [NUM_PORTS-1:0] req_i,
    input  logic [PORT_W-1:0]    last_grant_i,
    output logic [NUM_PORTS-1:0] grant_o
);

    logic found;
    int   target;

    always_comb begin
        grant_o = '0;
        found   = 1'b0;
        target  = 0;
        for (int off = 1; off <= NUM_PORTS; off++) begin
            target = int'(last_grant_i) + off;
            if (target >= NUM_PORTS) begin
                target = target - NUM_PORTS;
            end
            for (int p = 0; p < NUM_PORTS; p++) begin
                if (!found && req_i[p] && (p == target)) begin
                    grant_o[p] = 1'b1;
                    found      = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Multi-port memory arbiter: round-robin grant, one RAM transaction in flight.
// Optional per-port acceptance counters on grant_count_o when MEM_ARB_PERF_EN is defined.
//
//   state    | meaning
//   ST_IDLE  | accept one granted request; reserved ops go straight to ST_RESP
//   ST_ISSUE | ram_enable_o high for exactly this cycle
//   ST_WAIT  | down-count RAM_LAT-1 cycles, capture RAM response at terminal count
//   ST_RESP  | rsp_valid_o strobe to originating port, update last grant
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int  NUM_PORTS = DEF_NUM_PORTS,
    parameter int  ADDR_W    = DEF_ADDR_W,
    parameter int  DATA_W    = DEF_DATA_W,
    parameter int  RAM_LAT   = DEF_RAM_LAT,
    localparam int MASK_W    = DATA_W / 8
) (
    input  logic                        clk_i,
    input  logic                        reset_i,
    input  logic [NUM_PORTS-1:0]        req_valid_i,
    output logic [NUM_PORTS-1:0]        req_ready_o,
    input  logic [2*NUM_PORTS-1:0]      req_op_i,
    input  logic [MASK_W*NUM_PORTS-1:0] req_mask_i,
    input  logic [ADDR_W*NUM_PORTS-1:0] req_addr_i,
    input  logic [DATA_W*NUM_PORTS-1:0] req_data_i,
    output logic [NUM_PORTS-1:0]        rsp_valid_o,
    output logic [DATA_W-1:0]           rsp_data_o,
    output logic [1:0]                  rsp_fault_o,
    output logic                        ram_enable_o,
    output logic [1:0]                  ram_op_o,
    output logic [MASK_W-1:0]           ram_mask_o,
    output logic [ADDR_W-1:0]           ram_addr_o,
    output logic [DATA_W-1:0]           ram_data_o,
    input  logic [DATA_W-1:0]           ram_resp_i,
    input  logic [1:0]                  ram_fault_i
`ifdef MEM_ARB_PERF_EN
    ,
    output logic [32*NUM_PORTS-1:0]     grant_count_o
`endif
);

    localparam int PORT_W = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
    localparam int CNT_W  = (RAM_LAT > 1) ? $clog2(RAM_LAT) : 1;
    localparam logic [PORT_W-1:0] LAST_PORT = PORT_W'(NUM_PORTS - 1);
    localparam logic [CNT_W-1:0]  WAIT_INIT = CNT_W'(RAM_LAT - 1);

    arb_state_e            state_q;
    logic [PORT_W-1:0]     last_grant_q;
    logic [PORT_W-1:0]     port_q;
    logic [CNT_W-1:0]      wait_cnt_q;
    logic                  ram_enable_q;
    logic [1:0]            ram_op_q;
    logic [MASK_W-1:0]     ram_mask_q;
    logic [ADDR_W-1:0]     ram_addr_q;
    logic [DATA_W-1:0]     ram_data_q;
    logic [NUM_PORTS-1:0]  rsp_valid_q;
    logic [DATA_W-1:0]     rsp_data_q;
    logic [1:0]            rsp_fault_q;

    logic [NUM_PORTS-1:0]  grant;
    logic [PORT_W-1:0]     grant_idx;
    logic [1:0]            sel_op;
    logic [MASK_W-1:0]     sel_mask;
    logic [ADDR_W-1:0]     sel_addr;
    logic [DATA_W-1:0]     sel_data;
    logic                  accept;

    rr_arbiter #(.NUM_PORTS(NUM_PORTS)) u_rr (
        .req_i        (req_valid_i),
        .last_grant_i (last_grant_q),
        .grant_o      (grant)
    );

    always_comb begin
        grant_idx = '0;
        sel_op    = '0;
        sel_mask  = '0;
        sel_addr  = '0;
        sel_data  = '0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            if (grant[i]) begin
                grant_idx = PORT_W'(i);
                sel_op    = req_op_i[2*i +: 2];
                sel_mask  = req_mask_i[MASK_W*i +: MASK_W];
                sel_addr  = req_addr_i[ADDR_W*i +: ADDR_W];
                sel_data  = req_data_i[DATA_W*i +: DATA_W];
            end
        end
    end

    // Ready is combinational so a core sees acceptance in the same cycle it asks.
    assign req_ready_o = (state_q == ST_IDLE && !reset_i) ? grant : '0;
    assign accept      = |req_ready_o;

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q      <= ST_IDLE;
            last_grant_q <= LAST_PORT;
            port_q       <= '0;
            wait_cnt_q   <= '0;
            ram_enable_q <= 1'b0;
            ram_op_q     <= '0;
            ram_mask_q   <= '0;
            ram_addr_q   <= '0;
            ram_data_q   <= '0;
            rsp_valid_q  <= '0;
            rsp_data_q   <= '0;
            rsp_fault_q  <= '0;
        end else begin
            ram_enable_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (accept) begin
                        port_q <= grant_idx;
                        if (op_is_legal(sel_op)) begin
                            ram_enable_q <= 1'b1;
                            ram_op_q     <= sel_op;
                            ram_mask_q   <= sel_mask;
                            ram_addr_q   <= sel_addr;
                            ram_data_q   <= sel_data;
                            state_q      <= ST_ISSUE;
                        end else begin
                            rsp_valid_q <= grant;
                            rsp_data_q  <= '0;
                            rsp_fault_q <= FAULT_ILLEGAL;
                            state_q     <= ST_RESP;
                        end
                    end
                end
                ST_ISSUE: begin
                    wait_cnt_q <= WAIT_INIT;
                    state_q    <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (wait_cnt_q == '0) begin
                        rsp_valid_q <= NUM_PORTS'(1) << port_q;
                        rsp_data_q  <= (ram_op_q == OP_LOAD) ? ram_resp_i : '0;
                        rsp_fault_q <= ram_fault_i;
                        state_q     <= ST_RESP;
                    end else begin
                        wait_cnt_q <= wait_cnt_q - CNT_W'(1);
                    end
                end
                ST_RESP: begin
                    rsp_valid_q  <= '0;
                    rsp_data_q   <= '0;
                    rsp_fault_q  <= '0;
                    last_grant_q <= port_q;
                    state_q      <= ST_IDLE;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign ram_enable_o = ram_enable_q;
    assign ram_op_o     = ram_op_q;
    assign ram_mask_o   = ram_mask_q;
    assign ram_addr_o   = ram_addr_q;
    assign ram_data_o   = ram_data_q;
    assign rsp_valid_o  = rsp_valid_q;
    assign rsp_data_o   = rsp_data_q;
    assign rsp_fault_o  = rsp_fault_q;

`ifdef MEM_ARB_PERF_EN
    logic [31:0] grant_cnt_q [NUM_PORTS];

    // Counters saturate at all-ones instead of wrapping.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            for (int i = 0; i < NUM_PORTS; i++) begin
                grant_cnt_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_PORTS; i++) begin
                if (req_ready_o[i] && (grant_cnt_q[i] != '1)) begin
                    grant_cnt_q[i] <= grant_cnt_q[i] + 32'd1;
                end
            end
        end
    end

    always_comb begin
        grant_count_o = '0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            grant_count_o[32*i +: 32] = grant_cnt_q[i];
        end
    end
`else
    // Counters are omitted entirely; arbitration timing is unaffected.
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: vector table on a RAM_LAT=1 instance plus
// hand-written sequences on RAM_LAT=1 and RAM_LAT=3 instances.
module tb_mem_arbiter;

    logic clk;
    logic rst;

    logic [1:0]   req_valid1, req_ready1, rsp_valid1;
    logic [3:0]   req_op1;
    logic [15:0]  req_mask1;
    logic [127:0] req_addr1, req_data1;
    logic [63:0]  rsp_data1;
    logic [1:0]   rsp_fault1;
    logic         ram_en1;
    logic [1:0]   ram_op1;
    logic [7:0]   ram_mask1;
    logic [63:0]  ram_addr1, ram_wdata1, ram_resp1;
    logic [1:0]   ram_fault1;
    logic [63:0]  rd_val1;
    logic [1:0]   rf_val1;
    logic [2:0]   en_sh1;

    logic [1:0]   req_valid3, req_ready3, rsp_valid3;
    logic [3:0]   req_op3;
    logic [15:0]  req_mask3;
    logic [127:0] req_addr3, req_data3;
    logic [63:0]  rsp_data3;
    logic [1:0]   rsp_fault3;
    logic         ram_en3;
    logic [1:0]   ram_op3;
    logic [7:0]   ram_mask3;
    logic [63:0]  ram_addr3, ram_wdata3, ram_resp3;
    logic [1:0]   ram_fault3;
    logic [63:0]  rd_val3;
    logic [1:0]   rf_val3;
    logic [2:0]   en_sh3;

`ifdef MEM_ARB_PERF_EN
    logic [63:0]  grant_count1, grant_count3;
`endif

    int n_vec = 0;
    int n_err = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    mem_arbiter #(.NUM_PORTS(2), .RAM_LAT(1)) dut1 (
        .clk_i(clk), .reset_i(rst),
        .req_valid_i(req_valid1), .req_ready_o(req_ready1),
        .req_op_i(req_op1), .req_mask_i(req_mask1),
        .req_addr_i(req_addr1), .req_data_i(req_data1),
        .rsp_valid_o(rsp_valid1), .rsp_data_o(rsp_data1), .rsp_fault_o(rsp_fault1),
        .ram_enable_o(ram_en1), .ram_op_o(ram_op1), .ram_mask_o(ram_mask1),
        .ram_addr_o(ram_addr1), .ram_data_o(ram_wdata1),
        .ram_resp_i(ram_resp1), .ram_fault_i(ram_fault1)
`ifdef MEM_ARB_PERF_EN
        , .grant_count_o(grant_count1)
`endif
    );

    mem_arbiter #(.NUM_PORTS(2), .RAM_LAT(3)) dut3 (
        .clk_i(clk), .reset_i(rst),
        .req_valid_i(req_valid3), .req_ready_o(req_ready3),
        .req_op_i(req_op3), .req_mask_i(req_mask3),
        .req_addr_i(req_addr3), .req_data_i(req_data3),
        .rsp_valid_o(rsp_valid3), .rsp_data_o(rsp_data3), .rsp_fault_o(rsp_fault3),
        .ram_enable_o(ram_en3), .ram_op_o(ram_op3), .ram_mask_o(ram_mask3),
        .ram_addr_o(ram_addr3), .ram_data_o(ram_wdata3),
        .ram_resp_i(ram_resp3), .ram_fault_i(ram_fault3)
`ifdef MEM_ARB_PERF_EN
        , .grant_count_o(grant_count3)
`endif
    );

    // RAM models: response is only meaningful RAM_LAT cycles after the strobe,
    // otherwise junk is driven so a mistimed capture shows up.
    always @(posedge clk) begin
        en_sh1 <= {en_sh1[1:0], ram_en1};
        en_sh3 <= {en_sh3[1:0], ram_en3};
    end
    assign ram_resp1  = en_sh1[0] ? rd_val1 : 64'hBAD0_BAD0_BAD0_BAD0;
    assign ram_fault1 = en_sh1[0] ? rf_val1 : 2'b10;
    assign ram_resp3  = en_sh3[2] ? rd_val3 : 64'hBAD0_BAD0_BAD0_BAD0;
    assign ram_fault3 = en_sh3[2] ? rf_val3 : 2'b10;

    typedef struct {
        int          port;
        logic [1:0]  op;
        logic [63:0] addr;
        logic [63:0] data;
        logic [7:0]  mask;
        logic [63:0] rdata;
        logic [1:0]  rfault;
        logic        exp_en;
        int          exp_lat;
        logic [63:0] exp_data;
        logic [1:0]  exp_fault;
    } vec_t;

    vec_t vecs [7];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic run_vec(input vec_t v);
        bit got;
        int lat;
        @(negedge clk);
        rd_val1 = v.rdata;
        rf_val1 = v.rfault;
        req_valid1 = '0;
        req_valid1[v.port] = 1'b1;
        req_op1[2*v.port +: 2]    = v.op;
        req_mask1[8*v.port +: 8]  = v.mask;
        req_addr1[64*v.port +: 64] = v.addr;
        req_data1[64*v.port +: 64] = v.data;
        got = 1'b0;
        for (int i = 0; i < 20 && !got; i++) begin
            #1;
            if (req_ready1[v.port]) got = 1'b1;
            else @(negedge clk);
        end
        chk("accept", 64'(got), 64'd1);
        @(negedge clk);
        req_valid1 = '0;
        chk("ram_enable_t1", 64'(ram_en1), 64'(v.exp_en));
        if (v.exp_en) begin
            chk("ram_op", 64'(ram_op1), 64'(v.op));
            chk("ram_addr", ram_addr1, v.addr);
            chk("ram_mask", 64'(ram_mask1), 64'(v.mask));
            chk("ram_data", ram_wdata1, v.data);
        end
        lat = 1;
        while (rsp_valid1 == '0 && lat < 12) begin
            @(negedge clk);
            lat++;
            chk("ram_enable_low", 64'(ram_en1), 64'd0);
        end
        chk("rsp_latency", 64'(lat), 64'(v.exp_lat));
        chk("rsp_valid", 64'(rsp_valid1), 64'(2'b01 << v.port));
        chk("rsp_data", rsp_data1, v.exp_data);
        chk("rsp_fault", 64'(rsp_fault1), 64'(v.exp_fault));
        @(negedge clk);
        chk("rsp_valid_drop", 64'(rsp_valid1), 64'd0);
        chk("rsp_data_idle", rsp_data1, 64'd0);
        chk("rsp_fault_idle", 64'(rsp_fault1), 64'd0);
    endtask

    initial begin
        int order [4];
        int ng;
        int lat;
        vec_t pv;

        vecs[0] = '{0, 2'b01, 64'h1000, 64'h0, 8'hFF, 64'hDEAD_BEEF, 2'b00, 1'b1, 3, 64'hDEAD_BEEF, 2'b00};
        vecs[1] = '{1, 2'b10, 64'h2008, 64'h1122_3344_5566_7788, 8'hFF, 64'h5555, 2'b00, 1'b1, 3, 64'h0, 2'b00};
        vecs[2] = '{1, 2'b11, 64'h3000, 64'h77, 8'h01, 64'h6666, 2'b00, 1'b0, 1, 64'h0, 2'b11};
        vecs[3] = '{0, 2'b00, 64'h3008, 64'h88, 8'h02, 64'h6666, 2'b01, 1'b0, 1, 64'h0, 2'b11};
        vecs[4] = '{0, 2'b01, 64'h4000, 64'h0, 8'hFF, 64'hCAFE, 2'b01, 1'b1, 3, 64'hCAFE, 2'b01};
        vecs[5] = '{1, 2'b01, 64'h4010, 64'h0, 8'hF0, 64'hFFFF_FFFF_FFFF_FFFF, 2'b10, 1'b1, 3, 64'hFFFF_FFFF_FFFF_FFFF, 2'b10};
        vecs[6] = '{0, 2'b10, 64'h5000, 64'hAABB_CCDD, 8'h0F, 64'h7777, 2'b01, 1'b1, 3, 64'h0, 2'b01};

        rst = 1'b1;
        req_valid1 = 2'b11;
        req_op1    = 4'b0101;
        req_mask1  = 16'hFFFF;
        req_addr1  = {64'h100, 64'h200};
        req_data1  = '0;
        rd_val1    = 64'h1;
        rf_val1    = 2'b00;
        req_valid3 = '0;
        req_op3    = '0;
        req_mask3  = '0;
        req_addr3  = '0;
        req_data3  = '0;
        rd_val3    = '0;
        rf_val3    = '0;

        // Reset state, with both ports already requesting
        repeat (4) @(negedge clk);
        #1;
        chk("reset_ready", 64'(req_ready1), 64'd0);
        chk("reset_rsp_valid", 64'(rsp_valid1), 64'd0);
        chk("reset_ram_enable", 64'(ram_en1), 64'd0);
        chk("reset_rsp_data", rsp_data1, 64'd0);
        chk("reset_rsp_fault", 64'(rsp_fault1), 64'd0);
        chk("reset_ram_addr", ram_addr1, 64'd0);
        chk("reset_ram_op", 64'(ram_op1), 64'd0);
        chk("reset_ram_enable3", 64'(ram_en3), 64'd0);
        @(negedge clk);
        rst = 1'b0;

        // Sustained requests on both ports: grants go 0,1,0,1
        ng = 0;
        for (int c = 0; c < 60 && ng < 4; c++) begin
            #1;
            if (req_ready1 != '0) begin
                chk("rr_onehot", 64'($onehot(req_ready1)), 64'd1);
                order[ng] = req_ready1[1] ? 1 : 0;
                ng++;
            end
            @(negedge clk);
        end
        req_valid1 = '0;
        chk("rr_grant_total", 64'(ng), 64'd4);
        for (int k = 0; k < 4; k++) begin
            if (k < ng) chk("rr_order", 64'(order[k]), 64'(k % 2));
        end
        repeat (6) @(negedge clk);

        for (int i = 0; i < 7; i++) begin
            run_vec(vecs[i]);
        end

`ifdef MEM_ARB_PERF_EN
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        pv = vecs[5];
        for (int i = 0; i < 5; i++) begin
            run_vec(pv);
        end
        chk("grant_count1", grant_count1[63:32], 64'd5);
        chk("grant_count0", grant_count1[31:0], 64'd0);
`endif

        // RAM_LAT=3 store with access fault
        @(negedge clk);
        rd_val3    = 64'h1234;
        rf_val3    = 2'b01;
        req_op3    = 4'b0010;
        req_mask3  = 16'h000F;
        req_addr3  = {64'h0, 64'h40};
        req_data3  = {64'h0, 64'hAABB};
        req_valid3 = 2'b01;
        #1;
        chk("lat3_accept", 64'(req_ready3), 64'd1);
        @(negedge clk);
        req_valid3 = '0;
        chk("lat3_ram_enable", 64'(ram_en3), 64'd1);
        chk("lat3_ram_mask", 64'(ram_mask3), 64'h0F);
        chk("lat3_ram_op", 64'(ram_op3), 64'd2);
        lat = 1;
        while (rsp_valid3 == '0 && lat < 12) begin
            @(negedge clk);
            lat++;
        end
        chk("lat3_latency", 64'(lat), 64'd5);
        chk("lat3_rsp_valid", 64'(rsp_valid3), 64'd1);
        chk("lat3_rsp_data", rsp_data3, 64'd0);
        chk("lat3_rsp_fault", 64'(rsp_fault3), 64'd1);
        @(negedge clk);
        chk("lat3_rsp_drop", 64'(rsp_valid3), 64'd0);

        // Reset while waiting on the RAM: response discarded, port0 wins next
        @(negedge clk);
        req_op3    = 4'b0101;
        req_valid3 = 2'b10;
        #1;
        chk("abort_accept", 64'(req_ready3), 64'd2);
        @(negedge clk);
        req_valid3 = '0;
        chk("abort_ram_enable", 64'(ram_en3), 64'd1);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            chk("abort_no_rsp", 64'(rsp_valid3), 64'd0);
        end
        req_valid3 = 2'b11;
        #1;
        chk("abort_next_grant", 64'(req_ready3), 64'd1);
        @(negedge clk);
        req_valid3 = '0;
        repeat (8) @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end

endmodule
